wb_sim_slave_ram: RTL and testbench



---
 rtl/wb_sim_slave_ram_if.sv | 24 ++
 rtl/wb_sim_slave_ram.sv | 157 +++++++++++++++
 tb/tb_wb_sim_slave_ram.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_sim_slave_ram_if.sv
// Classic Wishbone bus bundle between a test master and the simulation RAM slave.
// Signal names keep the slave-side _i/_o suffixes so both ends read the same.
interface wb_sim_slave_ram_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [31:0]           wb_dat_i;
    logic [3:0]            wb_sel_i;
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_sim_slave_ram.sv
// Classic Wishbone slave RAM with programmable wait states, byte-lane writes
// and two access counters mapped just above the RAM (WRCNT, RDCNT).
module wb_sim_slave_ram #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        wait_i,
    wb_sim_slave_ram_if.slave wb
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] WRCNT_ADR = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RDCNT_ADR = ADDR_WIDTH'(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [31:0]           dat_q, dat_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           wr_count_q, wr_count_d;
    logic [31:0]           rd_count_q, rd_count_d;
    logic [31:0]           dat_o_q, dat_o_d;

    // Request seen at the commit edge: live bus inputs for zero-wait accepts,
    // latched copies otherwise.
    logic                  commit;
    logic [ADDR_WIDTH-1:0] c_adr;
    logic [31:0]           c_dat;
    logic [3:0]            c_sel;
    logic                  c_we;

    logic                  is_ram, is_wrcnt, is_rdcnt;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic                  mem_we;
    logic [31:0]           mem [0:DEPTH-1];

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        c_adr   = adr_q;
        c_dat   = dat_q;
        c_sel   = sel_q;
        c_we    = we_q;

        case (state_q)
            S_IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    adr_d = wb.wb_adr_i;
                    dat_d = wb.wb_dat_i;
                    sel_d = wb.wb_sel_i;
                    we_d  = wb.wb_we_i;
                    cnt_d = wait_i;
                    c_adr = wb.wb_adr_i;
                    c_dat = wb.wb_dat_i;
                    c_sel = wb.wb_sel_i;
                    c_we  = wb.wb_we_i;
                    if (wait_i == 4'd0) begin
                        commit  = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // An abort wins over a wait count that is just expiring.
                if (!wb.wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        is_ram     = (c_adr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
        is_wrcnt   = (c_adr == WRCNT_ADR);
        is_rdcnt   = (c_adr == RDCNT_ADR);
        mem_idx    = c_adr[DEPTH_LOG2-1:0];
        mem_we     = 1'b0;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        dat_o_d    = dat_o_q;

        if (commit && !rst_i) begin
            if (c_we) begin
                mem_we     = is_ram;
                wr_count_d = is_wrcnt ? 32'd0 : wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
                if (is_ram)        dat_o_d = mem[mem_idx];
                else if (is_wrcnt) dat_o_d = wr_count_q;
                else if (is_rdcnt) dat_o_d = rd_count_q;
                else               dat_o_d = 32'd0;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values computed by the combinational blocks above.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            dat_o_q    <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            dat_o_q    <= dat_o_d;
        end
    end

    // NOTE: the RAM array has no reset; contents survive rst_i and only the
    // write enable is gated by it.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (c_sel[k]) mem[mem_idx][8*k +: 8] <= c_dat[8*k +: 8];
            end
        end
    end

    assign wb.wb_ack_o = (state_q == S_ACK);
    assign wb.wb_dat_o = dat_o_q;

endmodule

// File: tb/tb_wb_sim_slave_ram.sv
// Directed bench for wb_sim_slave_ram: latency, byte lanes, abort, counters,
// unmapped space and reset behaviour, checked with immediate assertions.
module tb_wb_sim_slave_ram;
    localparam int AW = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] wait_v = 4'd0;
    int         total = 0;
    int         bad = 0;

    wb_sim_slave_ram_if #(.ADDR_WIDTH(AW)) bus ();

    wb_sim_slave_ram #(.ADDR_WIDTH(AW), .DEPTH_LOG2(8)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .wait_i (wait_v),
        .wb     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the ack cycle, with the bus idle. lat counts falling edges
    // from request to ack, i.e. wait states + 1.
    task automatic bus_op(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int chg_at, input logic [3:0] chg_val,
                          output logic [31:0] rd, output int lat);
        logic done;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (lat == chg_at) wait_v = chg_val;
            if (bus.wb_ack_o) done = 1'b1;
        end
        if (!done) check("ack_timeout", {31'b0, bus.wb_ack_o}, 32'd1);
        rd = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] r;
        int          l;
        bus_op(1'b1, adr, dat, sel, 0, 4'd0, r, l);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        int          l;
        bus_op(1'b0, adr, 32'd0, 4'hF, 0, 4'd0, r, l);
        check(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        int          l;
        logic        ack_seen;

        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("reset_dat", bus.wb_dat_o, 32'd0);

        // Zero wait states: ack in the cycle right after the accept edge.
        bus_op(1'b1, 32'h10, 32'hCAFEBABE, 4'hF, 0, 4'd0, r, l);
        check("w0_write_lat", 32'(l), 32'd1);
        bus_op(1'b0, 32'h10, 32'd0, 4'hF, 0, 4'd0, r, l);
        check("w0_read_lat", 32'(l), 32'd1);
        check("w0_read_dat", r, 32'hCAFEBABE);
        rd_chk("t1_rdcnt", 32'd257, 32'd1);
        rd_chk("t1_wrcnt", 32'd256, 32'd1);

        // Byte lanes (writes: 2..5, reads: 4..5).
        do_wr(32'h20, 32'h00000000, 4'hF);
        do_wr(32'h20, 32'h11000000, 4'b1000);
        do_wr(32'h20, 32'h00000022, 4'b0001);
        rd_chk("lanes_a", 32'h20, 32'h11000022);
        do_wr(32'h20, 32'hFFFFAAAA, 4'b0011);
        rd_chk("lanes_b", 32'h20, 32'h1100AAAA);

        // Five wait states; wait_i changed mid-access must be ignored (rd 6).
        wait_v = 4'd5;
        bus_op(1'b0, 32'h10, 32'd0, 4'hF, 2, 4'd2, r, l);
        check("w5_lat", 32'(l), 32'd6);
        check("w5_dat", r, 32'hCAFEBABE);
        check("w5_ack_one_cycle", {31'b0, bus.wb_ack_o}, 32'd0);
        wait_v = 4'd0;

        // Abort: word 3 preset to 0 (wr 6), write aborted after 2 cycles.
        do_wr(32'h3, 32'h00000000, 4'hF);
        wait_v = 4'd7;
        bus.wb_adr_i = 32'h3;
        bus.wb_dat_i = 32'h12345678;
        bus.wb_sel_i = 4'hF;
        bus.wb_we_i  = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        ack_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            ack_seen |= bus.wb_ack_o;
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            ack_seen |= bus.wb_ack_o;
        end
        check("abort_no_ack", {31'b0, ack_seen}, 32'd0);
        wait_v = 4'd0;
        rd_chk("abort_word3", 32'h3, 32'h00000000);
        rd_chk("abort_wrcnt", 32'd256, 32'd6);

        // Counters: clear WRCNT, 3 writes, 2 reads (rd 8 -> 10).
        do_wr(32'd256, 32'hDEADBEEF, 4'hF);
        do_wr(32'h30, 32'h1, 4'hF);
        do_wr(32'h31, 32'h2, 4'hF);
        do_wr(32'h32, 32'h3, 4'hF);
        rd_chk("cnt_ram30", 32'h30, 32'h1);
        rd_chk("cnt_ram31", 32'h31, 32'h2);
        rd_chk("cnt_rdcnt", 32'd257, 32'd10);
        rd_chk("cnt_wrcnt", 32'd256, 32'd3);
        do_wr(32'd256, 32'h0, 4'hF);
        rd_chk("cnt_wrcnt_clr", 32'd256, 32'd0);
        do_wr(32'd257, 32'h0000FFFF, 4'hF);
        rd_chk("cnt_rdcnt_ro", 32'd257, 32'd13);

        // Unmapped space must not alias onto RAM word 0.
        do_wr(32'h0, 32'hA5A5A5A5, 4'hF);
        do_wr(32'h1000, 32'h5A5A5A5A, 4'hF);
        bus_op(1'b0, 32'h1000, 32'd0, 4'hF, 0, 4'd0, r, l);
        check("unmap_lat", 32'(l), 32'd1);
        check("unmap_dat", r, 32'h00000000);
        rd_chk("unmap_no_alias", 32'h0, 32'hA5A5A5A5);
        rd_chk("unmap_wrcnt", 32'd256, 32'd3);

        // Reset during WAIT.
        wait_v = 4'd7;
        bus.wb_adr_i = 32'h10;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("rst_mid_dat", bus.wb_dat_o, 32'd0);
        rst = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        wait_v = 4'd0;
        @(negedge clk);
        rd_chk("rst_rdcnt", 32'd257, 32'd0);
        rd_chk("rst_wrcnt", 32'd256, 32'd0);
        bus_op(1'b0, 32'h10, 32'd0, 4'hF, 0, 4'd0, r, l);
        check("rst_after_lat", 32'(l), 32'd1);
        check("rst_ram_kept_10", r, 32'hCAFEBABE);
        rd_chk("rst_ram_kept_20", 32'h20, 32'h1100AAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
